// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared constants for the EX/MEM skid register: exception codes and occupancy width.
package ex_mem_skid_reg_pkg;

    localparam int unsigned EXP_W = 3;
    localparam int unsigned OCC_W = 2;

    localparam logic [EXP_W-1:0] ISA_EXP_NO_EXP   = 3'd0;
    localparam logic [EXP_W-1:0] ISA_EXP_EXT_INT  = 3'd1;
    localparam logic [EXP_W-1:0] ISA_EXP_OVERFLOW = 3'd3;

    // Exception code stored for an accepted beat; interrupt wins over overflow.
    function automatic logic [EXP_W-1:0] inject_exp(input logic int_detect,
                                                    input logic alu_of,
                                                    input logic [EXP_W-1:0] exp_in);
        if (int_detect)  return ISA_EXP_EXT_INT;
        else if (alu_of) return ISA_EXP_OVERFLOW;
        else             return exp_in;
    endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// Single EX/MEM payload slot (pc, data, ctrl, exp) with load and clear-to-reset-value.
module ex_mem_entry
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        CTRL_W    = 14,
    parameter logic [CTRL_W-1:0]  CTRL_KILL = CTRL_W'(1)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [EXP_W-1:0]  d_exp,
    output logic [PC_W-1:0]   q_pc,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [EXP_W-1:0]  q_exp
);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            q_pc   <= '0;
            q_data <= '0;
            q_ctrl <= CTRL_KILL;
            q_exp  <= ISA_EXP_NO_EXP;
        end else if (clear) begin
            q_pc   <= '0;
            q_data <= '0;
            q_ctrl <= CTRL_KILL;
            q_exp  <= ISA_EXP_NO_EXP;
        end else if (load) begin
            q_pc   <= d_pc;
            q_data <= d_data;
            q_ctrl <= d_ctrl;
            q_exp  <= d_exp;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake and exception injection.
// EX_MEM_SKID_EN selects the 2-entry skid buffer; otherwise a single entry is used.
module ex_mem_skid_reg
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        CTRL_W    = 14,
    parameter logic [CTRL_W-1:0]  CTRL_KILL = CTRL_W'(1)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [EXP_W-1:0]  in_exp_code,
    input  logic              alu_of,
    input  logic              int_detect,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [EXP_W-1:0]  out_exp_code,
    output logic [OCC_W-1:0]  occupancy
);

    logic              in_fire;
    logic              out_fire;
    logic              head_load;
    logic [PC_W-1:0]   inj_pc;
    logic [DATA_W-1:0] inj_data;
    logic [CTRL_W-1:0] inj_ctrl;
    logic [EXP_W-1:0]  inj_exp;
    logic [PC_W-1:0]   head_d_pc;
    logic [DATA_W-1:0] head_d_data;
    logic [CTRL_W-1:0] head_d_ctrl;
    logic [EXP_W-1:0]  head_d_exp;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready & ~flush;

    // Interrupt/overflow turn the beat into a side-effect-free exception carrier.
    always_comb begin
        inj_pc   = in_pc;
        inj_data = in_data;
        inj_ctrl = in_ctrl;
        inj_exp  = inject_exp(int_detect, alu_of, in_exp_code);
        if (int_detect | alu_of) begin
            inj_data = '0;
            inj_ctrl = CTRL_KILL;
        end
    end

`ifdef EX_MEM_SKID_EN
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_nxt;
    logic              head_from_skid;
    logic              skid_load;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [EXP_W-1:0]  skid_exp;

    // Slot steering: new beats land in the first free position, pops shift skid to head.
    always_comb begin
        occ_nxt        = occ_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            occ_nxt = '0;
        end else if (in_fire && !out_fire) begin
            occ_nxt = occ_q + OCC_W'(1);
            if (occ_q == OCC_W'(0)) head_load = 1'b1;
            else                    skid_load = 1'b1;
        end else if (!in_fire && out_fire) begin
            occ_nxt = occ_q - OCC_W'(1);
            if (occ_q == OCC_W'(2)) begin
                head_load      = 1'b1;
                head_from_skid = 1'b1;
            end
        end else if (in_fire && out_fire) begin
            head_load = 1'b1;
            if (occ_q == OCC_W'(2)) begin
                head_from_skid = 1'b1;
                skid_load      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occ_q     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            occ_q     <= occ_nxt;
            out_valid <= (occ_nxt != OCC_W'(0));
            in_ready  <= (occ_nxt != OCC_W'(2));
        end
    end

    assign occupancy   = occ_q;
    assign head_d_pc   = head_from_skid ? skid_pc   : inj_pc;
    assign head_d_data = head_from_skid ? skid_data : inj_data;
    assign head_d_ctrl = head_from_skid ? skid_ctrl : inj_ctrl;
    assign head_d_exp  = head_from_skid ? skid_exp  : inj_exp;

    ex_mem_entry #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CTRL_KILL (CTRL_KILL)
    ) u_skid (
        .clk    (clk),
        .reset_ (reset_),
        .load   (skid_load),
        .clear  (flush),
        .d_pc   (inj_pc),
        .d_data (inj_data),
        .d_ctrl (inj_ctrl),
        .d_exp  (inj_exp),
        .q_pc   (skid_pc),
        .q_data (skid_data),
        .q_ctrl (skid_ctrl),
        .q_exp  (skid_exp)
    );
`else
    logic valid_nxt;

    // Single entry: the slot frees up in the same cycle the downstream takes it.
    assign in_ready = out_ready | ~out_valid;

    always_comb begin
        valid_nxt = out_valid;
        if (flush)         valid_nxt = 1'b0;
        else if (in_fire)  valid_nxt = 1'b1;
        else if (out_fire) valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) out_valid <= 1'b0;
        else         out_valid <= valid_nxt;
    end

    assign head_load   = in_fire;
    assign occupancy   = {1'b0, out_valid};
    assign head_d_pc   = inj_pc;
    assign head_d_data = inj_data;
    assign head_d_ctrl = inj_ctrl;
    assign head_d_exp  = inj_exp;
`endif

    ex_mem_entry #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CTRL_KILL (CTRL_KILL)
    ) u_head (
        .clk    (clk),
        .reset_ (reset_),
        .load   (head_load),
        .clear  (flush),
        .d_pc   (head_d_pc),
        .d_data (head_d_data),
        .d_ctrl (head_d_ctrl),
        .d_exp  (head_d_exp),
        .q_pc   (out_pc),
        .q_data (out_data),
        .q_ctrl (out_ctrl),
        .q_exp  (out_exp_code)
    );

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: queue-based reference model plus directed literal checks.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [13:0] ctrl;
        logic [2:0]  exp;
    } beat_t;

    localparam logic [13:0] KILL = 14'd1;
    localparam beat_t RST_BEAT = '{pc: 32'd0, data: 32'd0, ctrl: 14'd1, exp: 3'd0};
`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_data = '0;
    logic [13:0] in_ctrl = '0;
    logic [2:0]  in_exp_code = '0;
    logic        alu_of = 1'b0;
    logic        int_detect = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    logic [13:0] out_ctrl;
    logic [2:0]  out_exp_code;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t q[$];
    beat_t shown = RST_BEAT;

    ex_mem_skid_reg dut (
        .clk          (clk),
        .reset_       (reset_),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_exp_code  (in_exp_code),
        .alu_of       (alu_of),
        .int_detect   (int_detect),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_exp_code (out_exp_code),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (CAP == 2) return q.size() != 2;
        else          return out_ready || q.size() == 0;
    endfunction

    function automatic beat_t injected();
        beat_t b;
        b = '{pc: in_pc, data: in_data, ctrl: in_ctrl, exp: in_exp_code};
        if (int_detect) begin
            b.data = 32'd0; b.ctrl = KILL; b.exp = 3'd1;
        end else if (alu_of) begin
            b.data = 32'd0; b.ctrl = KILL; b.exp = 3'd3;
        end
        return b;
    endfunction

    // Reference model: an ordered queue of beats and the last value shown at the head.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            q.delete();
            shown = RST_BEAT;
        end else begin
            logic fin, fout;
            fin  = in_valid && model_ready() && !flush;
            fout = (q.size() != 0) && out_ready && !flush;
            if (flush) begin
                q.delete();
                shown = RST_BEAT;
            end else begin
                if (fout) void'(q.pop_front());
                if (fin)  q.push_back(injected());
                if (q.size() != 0) shown = q[0];
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle, mid-low-phase.
    always @(negedge clk) begin
        beat_t h;
        #2;
        h = (q.size() != 0) ? q[0] : shown;
        chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("m_occupancy", 64'(occupancy), 64'(q.size()));
        chk("m_in_ready", 64'(in_ready), 64'(model_ready()));
        chk("m_out_pc", 64'(out_pc), 64'(h.pc));
        chk("m_out_data", 64'(out_data), 64'(h.data));
        chk("m_out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
        chk("m_out_exp", 64'(out_exp_code), 64'(h.exp));
    end

    task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] data,
                       input logic of, input logic intd, input logic fl, input logic ordy);
        @(negedge clk);
        in_valid    = v;
        in_pc       = pc;
        in_data     = data;
        in_ctrl     = 14'h2a5a;
        in_exp_code = 3'd0;
        alu_of      = of;
        int_detect  = intd;
        flush       = fl;
        out_ready   = ordy;
        #3;
    endtask

    task automatic idle(input logic ordy);
        put(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(KILL));
        chk("rst_out_exp", 64'(out_exp_code), 64'd0);
        @(negedge clk);
        reset_ = 1'b1;

        // Streaming without bubbles
        put(1'b1, 32'h40, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        put(1'b1, 32'h44, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("str_data0", 64'(out_data), 64'h10);
        chk("str_ctrl0", 64'(out_ctrl), 64'h2a5a);
        put(1'b1, 32'h48, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("str_data1", 64'(out_data), 64'h11);
        chk("str_valid1", 64'(out_valid), 64'd1);
        idle(1'b1);
        chk("str_data2", 64'(out_data), 64'h12);
        idle(1'b1);
        chk("str_empty_valid", 64'(out_valid), 64'd0);
        chk("str_empty_hold", 64'(out_data), 64'h12);

        // Backpressure
`ifdef EX_MEM_SKID_EN
        put(1'b1, 32'h50, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h54, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        idle(1'b0);
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_rdy_low", 64'(in_ready), 64'd0);
        idle(1'b1);
        chk("bp_head_a", 64'(out_data), 64'hA0);
        chk("bp_rdy_still_low", 64'(in_ready), 64'd0);
        idle(1'b1);
        chk("bp_head_b", 64'(out_data), 64'hB0);
        chk("bp_rdy_back", 64'(in_ready), 64'd1);
        idle(1'b1);
        chk("bp_drained", 64'(occupancy), 64'd0);
`else
        put(1'b1, 32'h50, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h54, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("so_rdy_eq_ordy0", 64'(in_ready), 64'd0);
        chk("so_head_a", 64'(out_data), 64'hA0);
        put(1'b1, 32'h54, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("so_rdy_eq_ordy1", 64'(in_ready), 64'd1);
        chk("so_occ1", 64'(occupancy), 64'd1);
        idle(1'b0);
        chk("so_head_b", 64'(out_data), 64'hB0);
        chk("so_rdy_eq_ordy0b", 64'(in_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        chk("so_drained", 64'(occupancy), 64'd0);
`endif

        // Overflow and interrupt injection
        put(1'b1, 32'h100, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("of_pc", 64'(out_pc), 64'h100);
        chk("of_data", 64'(out_data), 64'd0);
        chk("of_ctrl", 64'(out_ctrl), 64'(KILL));
        chk("of_exp", 64'(out_exp_code), 64'd3);
        put(1'b1, 32'h104, 32'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("int_exp", 64'(out_exp_code), 64'd1);
        chk("int_pc", 64'(out_pc), 64'h104);

        // Flush beats everything, including injection
        put(1'b1, 32'h200, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h204, 32'h88, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fl_pre_occ", 64'(occupancy), 64'd1);
        idle(1'b1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_pc_reset", 64'(out_pc), 64'd0);
        idle(1'b1);
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset while full
        put(1'b1, 32'h300, 32'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        put(1'b1, 32'h304, 32'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("ar_pre_occ", 64'(occupancy), 64'(CAP));
        #1 reset_ = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_rdy", 64'(in_ready), 64'd1);
        chk("ar_ctrl", 64'(out_ctrl), 64'(KILL));
        chk("ar_exp", 64'(out_exp_code), 64'd0);
        @(negedge clk);
        reset_ = 1'b1;

        // Randomised traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_pc       = $urandom;
            in_data     = $urandom;
            in_ctrl     = 14'($urandom);
            in_exp_code = 3'($urandom);
            alu_of      = ($urandom_range(0, 9) == 0);
            int_detect  = ($urandom_range(0, 19) == 0);
            flush       = ($urandom_range(0, 31) == 0);
            out_ready   = ($urandom_range(0, 9) < 6);
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
